// File: rtl/adder_seq_chunked.sv
// ============================================================================
// adder_seq_chunked : multi-cycle WIDTH-bit adder, CHUNK bits per clock,
// valid/ready on both sides. Optional ADDER_SUB_EN adds a subtract mode.
// Revision: 1.0
// ============================================================================
`default_nettype none

module adder_seq_chunked #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NCHUNK - 1);

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_chunk_check
      $error("adder_seq_chunked: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] b_in;
  logic             carry_in;
  logic [IW-1:0]    base;
  logic [CHUNK:0]   chunk_sum;

  // Subtraction is folded in at latch time: A - B == A + ~B + 1.
`ifdef ADDER_SUB_EN
  assign b_in     = sub ? ~B : B;
  assign carry_in = sub ? 1'b1 : Cin;
`else
  assign b_in     = B;
  assign carry_in = Cin;
`endif

  assign base      = IW'(cnt_q) * IW'(CHUNK);
  assign chunk_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = b_in;
          carry_d = carry_in;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        s_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d            = chunk_sum[CHUNK];
        if (cnt_q == C_LAST) begin
          cout_d  = chunk_sum[CHUNK];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign S         = s_q;
  assign Cout      = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_seq_chunked.sv
// ============================================================================
// tb_adder_seq_chunked : bench for adder_seq_chunked (32/8 and 64/64 builds).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_adder_seq_chunked;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] s;
  logic        cout;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [63:0] w_a = '0;
  logic [63:0] w_b = '0;
  logic        w_cin = 1'b0;
  logic        w_sub = 1'b0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b1;
  logic [63:0] w_s;
  logic        w_cout;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] sbq[$];
  logic        rand_done = 1'b0;

  always #5 clk = ~clk;

  adder_seq_chunked #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin),
`ifdef ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .S(s), .Cout(cout)
  );

  adder_seq_chunked #(.WIDTH(64), .CHUNK(64)) u_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .A(w_a), .B(w_b), .Cin(w_cin),
`ifdef ADDER_SUB_EN
    .sub(w_sub),
`endif
    .out_valid(w_out_valid), .out_ready(w_out_ready), .S(w_s), .Cout(w_cout)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        cout;
  } vec_t;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic sb);
    if (sb) model = {1'b0, x} + {1'b0, ~y} + 33'd1;
    else    model = {1'b0, x} + {1'b0, y} + {32'd0, c};
  endfunction

  // Present operands until accepted; expected result goes to the scoreboard.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c);
    int t;
    a = x; b = y; cin = c; in_valid = 1'b1;
    for (t = 0; t < 60; t++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    if (t == 60) check("send_timeout", 65'd1, 65'd0);
    sbq.push_back(model(x, y, c, sub));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) return;
    end
    check("valid_timeout", 65'd1, 65'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) check("sb_unexpected", 65'd1, 65'd0);
      else check("sb_result", {32'd0, cout, s}, {32'd0, sbq.pop_front()});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   lat;
    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
    vecs[1] = '{32'h12345678, 32'h0F0F0F0F, 1'b1, 32'h21436588, 1'b0};
    vecs[2] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vecs[5] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
    vecs[6] = '{32'h00FFFFFF, 32'h00000000, 1'b1, 32'h01000000, 1'b0};
    vecs[7] = '{32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {64'd0, in_ready}, 65'd1);
    check("rst_out_valid", {64'd0, out_valid}, 65'd0);
    check("rst_s", {33'd0, s}, 65'd0);
    check("rst_cout", {64'd0, cout}, 65'd0);
    check("rst_wide_s", {1'b0, w_s}, 65'd0);
    @(negedge clk);
    rst_n = 1'b1;

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_valid(lat);
      check("vec_latency", 65'(lat), 65'd4);
      check("vec_sum", {32'd0, cout, s}, {32'd0, vecs[i].cout, vecs[i].s});
    end

    // Backpressure: result must hold while out_ready is low; new operands ignored.
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h12345678, 32'h0F0F0F0F, 1'b1);
    wait_valid(lat);
    check("stall_latency", 65'(lat), 65'd4);
    for (int k = 0; k < 10; k++) begin
      check("stall_s", {33'd0, s}, {33'd0, 32'h21436588});
      check("stall_cout", {64'd0, cout}, 65'd0);
      check("stall_in_ready", {64'd0, in_ready}, 65'd0);
      check("stall_out_valid", {64'd0, out_valid}, 65'd1);
      if (k < 5) begin
        in_valid = 1'b1; a = 32'h11111111; b = 32'h22222222; cin = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready", {64'd0, in_ready}, 65'd1);
    check("release_out_valid", {64'd0, out_valid}, 65'd0);
    check("release_s_held", {33'd0, s}, {33'd0, 32'h21436588});

    // Reset during CALC discards the operation.
    send(32'hAAAAAAAA, 32'h55555555, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {64'd0, out_valid}, 65'd0);
    check("midrst_s", {33'd0, s}, 65'd0);
    check("midrst_cout", {64'd0, cout}, 65'd0);
    check("midrst_in_ready", {64'd0, in_ready}, 65'd1);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(32'd1, 32'd2, 1'b0);
    wait_valid(lat);
    check("postrst_latency", 65'(lat), 65'd4);
    check("postrst_sum", {32'd0, cout, s}, 65'd3);

    // Single-chunk instance: one CALC cycle.
    @(posedge clk);
    #1;
    w_a = 64'hFFFFFFFF_FFFFFFFF; w_b = 64'hFFFFFFFF_FFFFFFFF; w_cin = 1'b1;
    w_in_valid = 1'b1;
    @(posedge clk);
    #1 w_in_valid = 1'b0;
    lat = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (w_out_valid) break;
    end
    check("wide_latency", 65'(lat), 65'd1);
    check("wide_s", {1'b0, w_s}, {1'b0, 64'hFFFFFFFF_FFFFFFFF});
    check("wide_cout", {64'd0, w_cout}, 65'd1);

    // Random operands with random output stalls.
    fork
      begin
        for (int i = 0; i < 100; i++)
          send($urandom, $urandom, 1'($urandom_range(0, 1)));
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int t = 0; t < 100 && sbq.size() != 0; t++) @(negedge clk);
    check("sb_drained", 65'(sbq.size()), 65'd0);

`ifdef ADDER_SUB_EN
    sub = 1'b1;
    send(32'd5, 32'd7, 1'b1);
    wait_valid(lat);
    check("sub_5_7", {32'd0, cout, s}, {32'd0, 1'b0, 32'hFFFFFFFE});
    send(32'd7, 32'd5, 1'b0);
    wait_valid(lat);
    check("sub_7_5", {32'd0, cout, s}, {32'd0, 1'b1, 32'h00000002});
    sub = 1'b0;
    send(32'd5, 32'd7, 1'b0);
    wait_valid(lat);
    check("add_5_7", {32'd0, cout, s}, 65'd12);
`endif

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
